imem_loader: RTL and testbench

//  Writer side of the instruction-memory read path used by the multicycle RISC-V core.

---
 rtl/imem_loader_pkg.sv | 22 ++
 rtl/imem_loader_if.sv | 30 +++
 rtl/imem_loader_byte_packer.sv | 38 +++
 rtl/imem_loader.sv | 124 ++++++++++++
 tb/tb_imem_loader.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// Also holds the word-index to byte-address helper used by the top level.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    WRITE,
    DONE,
    ERR
  } loader_state_t;

  localparam int unsigned HDR_BYTES  = 4;
  localparam int unsigned WORD_BYTES = 4;

  // Byte address of a word slot; wraps modulo 2^32 with the adder.
  function automatic logic [31:0] wordAddr(input logic [31:0] base, input logic [31:0] index);
    return base + (index << 2);
  endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The master modport is the loader's view; slave is the source/memory side.
interface imem_loader_if;

  logic        inValid;
  logic [7:0]  inData;
  logic        inReady;
  logic        memWr;
  logic [31:0] memAddr;
  logic [31:0] memData;

  modport master (
    input  inValid,
    input  inData,
    output inReady,
    output memWr,
    output memAddr,
    output memData
  );

  modport slave (
    output inValid,
    output inData,
    input  inReady,
    input  memWr,
    input  memAddr,
    input  memData
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word packer shared by the header count and the data words.
// The word output already includes the byte being accepted, so it is valid alongside wordReady.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  inByte,
  output logic [31:0] word,
  output logic        wordReady
);

  localparam int unsigned PACK_BYTES = (HDR_BYTES > WORD_BYTES) ? HDR_BYTES : WORD_BYTES;
  localparam logic [1:0]  LAST_BYTE  = 2'(PACK_BYTES - 1);

  logic [1:0]  byteCount;
  logic [23:0] shiftReg;

  // Earlier bytes shift down so the first byte of a group ends up in bits [7:0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byteCount <= 2'd0;
      shiftReg  <= 24'd0;
    end else if (clear) begin
      byteCount <= 2'd0;
      shiftReg  <= 24'd0;
    end else if (accept) begin
      byteCount <= byteCount + 2'd1;
      shiftReg  <= {inByte, shiftReg[23:8]};
    end
  end

  assign word      = {inByte, shiftReg};
  assign wordReady = accept && (byteCount == LAST_BYTE);

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte image into instruction memory, one 32-bit word at a time,
// keeping the core in reset until the whole image has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  imem_loader_if.master bus,
  output logic          cpuReset,
  output logic          busy,
  output logic          done,
  output logic          error
);

  loader_state_t state;
  loader_state_t nextState;

  logic [31:0] nWords;
  logic [31:0] wordIndex;
  logic [31:0] memDataReg;

  logic        packClear;
  logic        packAccept;
  logic [31:0] packWord;
  logic        packWordReady;

  byte_packer packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (packClear),
    .accept    (packAccept),
    .inByte    (bus.inData),
    .word      (packWord),
    .wordReady (packWordReady)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Start is only honoured when no load is running, so a pulse during HDR/DATA/WRITE is dropped.
  always_comb begin
    nextState = state;
    packClear = 1'b0;
    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          nextState = HDR;
          packClear = 1'b1;
        end
      end
      HDR: begin
        if (packWordReady) begin
          if (packWord == 32'd0) begin
            nextState = DONE;
          end else if (packWord > 32'(DEPTH_WORDS)) begin
            nextState = ERR;
          end else begin
            nextState = DATA;
          end
        end
      end
      DATA: begin
        if (packWordReady) begin
          nextState = WRITE;
        end
      end
      WRITE: begin
        if (wordIndex + 32'd1 == nWords) begin
          nextState = DONE;
        end else begin
          nextState = DATA;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // The index stays on the last word after the final write so it never passes N-1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nWords     <= 32'd0;
      wordIndex  <= 32'd0;
      memDataReg <= 32'd0;
    end else begin
      if (packClear) begin
        wordIndex <= 32'd0;
      end
      if (state == HDR && packWordReady) begin
        nWords <= packWord;
      end
      if (state == DATA && packWordReady) begin
        memDataReg <= packWord;
      end
      if (state == WRITE && nextState == DATA) begin
        wordIndex <= wordIndex + 32'd1;
      end
    end
  end

  assign bus.inReady = (state == HDR) || (state == DATA);
  assign packAccept  = bus.inValid && bus.inReady;
  assign bus.memWr   = (state == WRITE);
  assign bus.memAddr = wordAddr(BASE_ADDR, wordIndex);
  assign bus.memData = memDataReg;

  // Restart from DONE re-asserts core reset in the very cycle Start is seen.
  assign cpuReset = !((state == DONE) && !start);
  assign busy     = (state == HDR) || (state == DATA) || (state == WRITE);
  assign done     = (state == DONE);
  assign error    = (state == ERR);

  memWrSingleCycle: assert property (@(posedge clk) disable iff (rst) bus.memWr |=> !bus.memWr);
  cpuReleaseOnlyInDone: assert property (@(posedge clk) disable iff (rst) !cpuReset |-> state == DONE);

endmodule

// File: tb/tb_imem_loader.sv
// Randomised self-checking bench for imem_loader against an image-level reference model.
// Expected writes are derived directly from the byte image, independent of the loader's FSM.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam logic [31:0] BASE  = 32'h0;
  localparam int          DEPTH = 256;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic cpuReset;
  logic busy;
  logic done;
  logic error;

  imem_loader_if bus ();

  imem_loader #(
    .BASE_ADDR   (BASE),
    .DEPTH_WORDS (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .cpuReset (cpuReset),
    .busy     (busy),
    .done     (done),
    .error    (error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  logic [7:0]  image[$];
  logic [31:0] expAddrQ[$];
  logic [31:0] expDataQ[$];
  logic [31:0] wrAddrQ[$];
  logic [31:0] wrDataQ[$];
  logic [31:0] memModel [DEPTH];
  bit          expDone;
  bit          expError;

  // Observed memory writes, recorded mid-cycle while the strobe is stable.
  always @(negedge clk) begin
    logic [31:0] offset;
    if (bus.memWr === 1'b1) begin
      wrAddrQ.push_back(bus.memAddr);
      wrDataQ.push_back(bus.memData);
      offset = (bus.memAddr - BASE) >> 2;
      if (offset < DEPTH) memModel[offset] = bus.memData;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed === expected) passed++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
  endtask

  // Reference model: count word first, then N little-endian words at consecutive slots.
  task automatic buildExpected();
    logic [31:0] n;
    expAddrQ.delete();
    expDataQ.delete();
    n = {image[3], image[2], image[1], image[0]};
    expError = (n > DEPTH);
    expDone  = !expError;
    if (!expError) begin
      for (int i = 0; i < int'(n); i++) begin
        expAddrQ.push_back(BASE + 32'(4 * i));
        expDataQ.push_back({image[4 + 4 * i + 3], image[4 + 4 * i + 2],
                            image[4 + 4 * i + 1], image[4 + 4 * i]});
      end
    end
  endtask

  task automatic makeRandomImage(input int n);
    logic [31:0] count;
    count = 32'(n);
    image.delete();
    for (int i = 0; i < 4; i++) image.push_back(count[8 * i +: 8]);
    for (int i = 0; i < 4 * n; i++) image.push_back(8'($urandom));
  endtask

  task automatic makeFixedImage();
    image = '{8'h02, 8'h00, 8'h00, 8'h00,
              8'h13, 8'h00, 8'h00, 8'h00,
              8'h93, 8'h00, 8'h10, 8'h00};
  endtask

  // mode 0: valid always high, 1: toggling, 2: random. startAt re-pulses Start at that byte index.
  task automatic applyStimulus(input int mode, input int startAt, input int nBytes);
    int  idx = 0;
    int  cyc = 0;
    int  budget = 10 * nBytes + 50;
    bit  v;
    bit  pulsed = 0;
    while (idx < nBytes && cyc < budget) begin
      @(negedge clk);
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      if (!pulsed && idx == startAt) begin
        start  = 1'b1;
        pulsed = 1'b1;
      end else begin
        start = 1'b0;
      end
      bus.inValid = v;
      bus.inData  = v ? image[idx] : 8'($urandom);
      if (v && bus.inReady) idx++;
      cyc++;
    end
    if (idx < nBytes) checkOutput("stream_timeout", 32'(idx), 32'(nBytes));
    @(negedge clk);
    bus.inValid = 1'b0;
    start       = 1'b0;
  endtask

  task automatic waitFinish();
    int c = 0;
    while (!(done || error) && c < 60) begin
      @(negedge clk);
      c++;
    end
    checkOutput("finish", 32'(done | error), 32'd1);
  endtask

  task automatic compareLoad(input string name, input bit perWord);
    logic [31:0] gotA;
    logic [31:0] gotD;
    checkOutput({name, "_wrcount"}, 32'(wrAddrQ.size()), 32'(expAddrQ.size()));
    if (perWord) begin
      for (int i = 0; i < expAddrQ.size(); i++) begin
        gotA = (i < wrAddrQ.size()) ? wrAddrQ[i] : 32'hxxxxxxxx;
        gotD = (i < wrDataQ.size()) ? wrDataQ[i] : 32'hxxxxxxxx;
        checkOutput({name, "_addr"}, gotA, expAddrQ[i]);
        checkOutput({name, "_data"}, gotD, expDataQ[i]);
      end
    end
    checkOutput({name, "_done"}, 32'(done), 32'(expDone));
    checkOutput({name, "_error"}, 32'(error), 32'(expError));
    checkOutput({name, "_cpuReset"}, 32'(cpuReset), 32'(!expDone));
    checkOutput({name, "_inReady"}, 32'(bus.inReady), 32'd0);
    checkOutput({name, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic runLoad(input string name, input int mode, input int startAt, input bit fromDone,
                         input bit perWord);
    wrAddrQ.delete();
    wrDataQ.delete();
    buildExpected();
    @(negedge clk);
    start = 1'b1;
    if (fromDone) begin
      #1;
      checkOutput({name, "_startCpuReset"}, 32'(cpuReset), 32'd1);
      checkOutput({name, "_startDoneHeld"}, 32'(done), 32'd1);
    end
    applyStimulus(mode, startAt, image.size());
    waitFinish();
    compareLoad(name, perWord);
  endtask

  task automatic checkResetValues(input string name);
    checkOutput({name, "_inReady"}, 32'(bus.inReady), 32'd0);
    checkOutput({name, "_memWr"}, 32'(bus.memWr), 32'd0);
    checkOutput({name, "_memAddr"}, bus.memAddr, BASE);
    checkOutput({name, "_memData"}, bus.memData, 32'd0);
    checkOutput({name, "_cpuReset"}, 32'(cpuReset), 32'd1);
    checkOutput({name, "_busy"}, 32'(busy), 32'd0);
    checkOutput({name, "_done"}, 32'(done), 32'd0);
    checkOutput({name, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    bus.inValid = 1'b0;
    bus.inData  = 8'h00;
    @(negedge clk);
    checkResetValues("por");
    @(negedge clk);
    rst = 1'b0;

    // Abort a load after two bytes of the second word; only the first word may reach memory.
    makeFixedImage();
    wrAddrQ.delete();
    wrDataQ.delete();
    @(negedge clk);
    start = 1'b1;
    applyStimulus(0, -1, 10);
    rst = 1'b1;
    #1;
    checkResetValues("midReset");
    checkOutput("midReset_wrcount", 32'(wrAddrQ.size()), 32'd1);
    checkOutput("midReset_word0", (wrDataQ.size() > 0) ? wrDataQ[0] : 32'hxxxxxxxx, 32'h00000013);
    @(negedge clk);
    rst = 1'b0;

    makeFixedImage();
    runLoad("fixed", 0, -1, 1'b0, 1'b1);
    checkOutput("fixed_word1", (wrDataQ.size() > 1) ? wrDataQ[1] : 32'hxxxxxxxx, 32'h00100093);
    checkOutput("fixed_addr1", (wrAddrQ.size() > 1) ? wrAddrQ[1] : 32'hxxxxxxxx, BASE + 32'd4);

    makeFixedImage();
    runLoad("toggle", 1, -1, 1'b0, 1'b1);

    image = '{8'h00, 8'h00, 8'h00, 8'h00};
    runLoad("empty", 2, -1, 1'b0, 1'b1);

    image = '{8'h01, 8'h01, 8'h00, 8'h00};
    runLoad("tooBig", 0, -1, 1'b0, 1'b1);

    for (int t = 0; t < 4; t++) begin
      makeRandomImage(int'($urandom_range(1, 12)));
      runLoad("random", 2, -1, 1'b0, 1'b1);
    end

    // Start on the 4th byte of the first data word and again while in DONE.
    makeRandomImage(5);
    runLoad("startBusy", 0, 7, 1'b0, 1'b1);
    makeRandomImage(3);
    runLoad("startDone", 2, -1, 1'b1, 1'b1);

    makeRandomImage(DEPTH);
    runLoad("full", 2, -1, 1'b1, 1'b0);
    checkOutput("full_lastAddr", (wrAddrQ.size() > 0) ? wrAddrQ[wrAddrQ.size() - 1] : 32'hxxxxxxxx,
                BASE + 32'(4 * (DEPTH - 1)));
    for (int i = 0; i < DEPTH; i++) begin
      checkOutput("full_mem", memModel[i], expDataQ[i]);
    end

    $display("[TB] %0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
